// File: rtl/plic_gateway_array.sv
// Multi-source PLIC interrupt gateway: per-source level/edge qualification,
// saturating edge-request counting and an ID-addressed claim/complete handshake.
module plic_gateway_array #(
    parameter int unsigned SRC_NUM   = 8,
    parameter int unsigned CNT_WIDTH = 4,
    parameter int unsigned ID_WIDTH  = $clog2(SRC_NUM + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [SRC_NUM-1:0]   irq_i,
    input  logic [SRC_NUM-1:0]   tm_i,
    input  logic [SRC_NUM-1:0]   pol_i,
    input  logic [CNT_WIDTH-1:0] tnm_i,
    input  logic                 claim_vld_i,
    input  logic [ID_WIDTH-1:0]  claim_id_i,
    input  logic                 comp_vld_i,
    input  logic [ID_WIDTH-1:0]  comp_id_i,
    output logic [SRC_NUM-1:0]   ip_o,
    output logic [SRC_NUM-1:0]   busy_o,
    output logic [SRC_NUM-1:0]   ovf_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_CLAIMED = 2'd2
    } gw_state_e;

    // A programmed limit of zero behaves as a limit of one.
    logic [CNT_WIDTH-1:0] lim;
    assign lim = (tnm_i == '0) ? CNT_WIDTH'(1) : tnm_i;

    for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_ch
        localparam logic [ID_WIDTH-1:0] CH_ID = ID_WIDTH'(gi + 1);

        gw_state_e            state;
        logic                 act;
        logic                 act_q;
        logic                 edge_det;
        logic                 claim_hit;
        logic                 comp_hit;
        logic                 consume;
        logic                 ovf_c;
        logic                 ip_r;
        logic                 busy_r;
        logic                 ovf_r;
        logic [CNT_WIDTH-1:0] cnt;
        logic [CNT_WIDTH-1:0] cnt_nxt;

        assign act       = irq_i[gi] ^ pol_i[gi];
        assign edge_det  = act & ~act_q;
        assign claim_hit = claim_vld_i && (claim_id_i == CH_ID);
        assign comp_hit  = comp_vld_i && (comp_id_i == CH_ID);
        assign consume   = claim_hit && (state == ST_PEND);

        // Next request count; an edge coinciding with a consume cancels out.
        always_comb begin
            cnt_nxt = cnt;
            ovf_c   = 1'b0;
            if (!tm_i[gi]) begin
                cnt_nxt = '0;
            end else if (edge_det && !consume) begin
                if (cnt < lim) begin
                    cnt_nxt = cnt + CNT_WIDTH'(1);
                end else begin
                    ovf_c = 1'b1;
                end
            end else if (consume && !edge_det && (cnt != '0)) begin
                cnt_nxt = cnt - CNT_WIDTH'(1);
            end
        end

        // Gateway FSM with outputs registered alongside the state.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                state  <= ST_IDLE;
                act_q  <= 1'b0;
                cnt    <= '0;
                ovf_r  <= 1'b0;
                ip_r   <= 1'b0;
                busy_r <= 1'b0;
            end else begin
                act_q <= act;
                cnt   <= cnt_nxt;
                ovf_r <= ovf_c;
                case (state)
                    ST_IDLE: begin
                        if ((!tm_i[gi] && act) || (tm_i[gi] && (cnt_nxt != '0))) begin
                            state <= ST_PEND;
                            ip_r  <= 1'b1;
                        end
                    end
                    ST_PEND: begin
                        if (claim_hit) begin
                            state  <= ST_CLAIMED;
                            ip_r   <= 1'b0;
                            busy_r <= 1'b1;
                        end
                    end
                    ST_CLAIMED: begin
                        if (comp_hit) begin
                            state  <= ST_IDLE;
                            busy_r <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        ip_r   <= 1'b0;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end

        assign ip_o[gi]   = ip_r;
        assign busy_o[gi] = busy_r;
        assign ovf_o[gi]  = ovf_r;
    end

endmodule

// File: tb/tb_plic_gateway_array.sv
// Bench for plic_gateway_array: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural reference model.
module tb_plic_gateway_array;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq, tm, pol;
    logic [3:0]   tnm;
    logic         claim_vld, comp_vld;
    logic [3:0]   claim_id, comp_id;
    logic [N-1:0] ip_o, busy_o, ovf_o;

    int tests = 0;
    int fails = 0;

    // Reference model: 0 = idle, 1 = pending, 2 = claimed.
    int m_st  [N];
    int m_cnt [N];
    bit m_act [N];
    bit m_ovf [N];

    plic_gateway_array #(.SRC_NUM(N), .CNT_WIDTH(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .irq_i(irq), .tm_i(tm), .pol_i(pol),
        .tnm_i(tnm), .claim_vld_i(claim_vld), .claim_id_i(claim_id),
        .comp_vld_i(comp_vld), .comp_id_i(comp_id),
        .ip_o(ip_o), .busy_o(busy_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int lim;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_cnt[i] = 0; m_act[i] = 0; m_ovf[i] = 0;
            end
            return;
        end
        lim = (tnm == 0) ? 1 : int'(tnm);
        for (int i = 0; i < N; i++) begin
            bit a, e, my_claim, my_comp, consume;
            a        = irq[i] ^ pol[i];
            e        = a && !m_act[i];
            my_claim = claim_vld && (int'(claim_id) == i + 1);
            my_comp  = comp_vld && (int'(comp_id) == i + 1);
            consume  = my_claim && (m_st[i] == 1);
            m_ovf[i] = 0;
            if (!tm[i]) m_cnt[i] = 0;
            else if (e && !consume) begin
                if (m_cnt[i] < lim) m_cnt[i]++;
                else m_ovf[i] = 1;
            end else if (consume && !e && m_cnt[i] > 0) m_cnt[i]--;
            if (m_st[i] == 0) begin
                if (tm[i] ? (m_cnt[i] != 0) : a) m_st[i] = 1;
            end else if (m_st[i] == 1) begin
                if (my_claim) m_st[i] = 2;
            end else begin
                if (my_comp) m_st[i] = 0;
            end
            m_act[i] = a;
        end
    endtask

    task automatic check_model();
        logic [N-1:0] e_ip, e_busy, e_ovf;
        for (int i = 0; i < N; i++) begin
            e_ip[i]   = (m_st[i] == 1);
            e_busy[i] = (m_st[i] == 2);
            e_ovf[i]  = m_ovf[i];
        end
        chk("model_ip", ip_o, e_ip);
        chk("model_busy", busy_o, e_busy);
        chk("model_ovf", ovf_o, e_ovf);
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs checked 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic claim(input int id);
        claim_vld = 1'b1; claim_id = 4'(id); cyc(); claim_vld = 1'b0; claim_id = '0;
    endtask

    task automatic complete(input int id);
        comp_vld = 1'b1; comp_id = 4'(id); cyc(); comp_vld = 1'b0; comp_id = '0;
    endtask

    initial begin
        int ovf_seen;
        logic [N-1:0] snap_ip, snap_busy;
        rst_n = 1'b0; irq = '0; tm = '0; pol = '0; tnm = 4'd0;
        claim_vld = 1'b0; claim_id = '0; comp_vld = 1'b0; comp_id = '0;
        for (int i = 0; i < N; i++) begin m_st[i] = 0; m_cnt[i] = 0; m_act[i] = 0; m_ovf[i] = 0; end
        cyc(); cyc();
        chk("reset_ip", ip_o, 8'h00);
        chk("reset_busy", busy_o, 8'h00);
        rst_n = 1'b1;
        cyc();

        // Level mode on source 0
        irq[0] = 1'b1; cyc();
        chk("level_assert", ip_o, 8'h01);
        cyc();
        claim(1);
        chk("level_claim_ip", ip_o, 8'h00);
        chk("level_claim_busy", busy_o, 8'h01);
        cyc();
        complete(1);
        chk("level_comp_gap", ip_o, 8'h00);
        cyc();
        chk("level_repend", ip_o, 8'h01);
        irq[0] = 1'b0;
        claim(1); complete(1); cyc();
        chk("level_drained", ip_o | busy_o, 8'h00);

        // Edge counting and saturation on source 2
        tm = 8'h04; tnm = 4'd3; ovf_seen = 0;
        for (int k = 0; k < 5; k++) begin
            irq[2] = 1'b1; cyc(); ovf_seen += int'(ovf_o[2]);
            irq[2] = 1'b0; cyc(); ovf_seen += int'(ovf_o[2]);
        end
        tests++;
        assert (ovf_seen === 2) else begin
            fails++;
            $error("FAIL sat_ovf_count observed=%0d expected=%0d", ovf_seen, 2);
        end
        for (int k = 0; k < 3; k++) begin
            chk("sat_pend", 8'(ip_o[2]), 8'h01);
            claim(3); complete(3); cyc();
        end
        chk("sat_drained", ip_o, 8'h00);

        // Simultaneous edge and claim on source 0
        tm = 8'h05;
        irq[0] = 1'b1; cyc();
        irq[0] = 1'b0; cyc();
        chk("sim_pend", ip_o, 8'h01);
        irq[0] = 1'b1; claim(1);
        chk("sim_busy", busy_o, 8'h01);
        chk("sim_no_ovf", ovf_o, 8'h00);
        complete(1); cyc();
        chk("sim_repend", ip_o, 8'h01);
        irq[0] = 1'b0;
        claim(1); complete(1); cyc();
        chk("sim_drained", ip_o, 8'h00);

        // Falling-edge polarity on source 4
        tm = 8'h15; irq[4] = 1'b1; pol[4] = 1'b1;
        cyc(); cyc();
        chk("fall_rise_nothing", ip_o, 8'h00);
        irq[4] = 1'b0; cyc();
        chk("fall_assert", ip_o, 8'h10);
        irq[4] = 1'b1; cyc();
        claim(5);
        chk("fall_claimed", busy_o, 8'h10);

        // Invalid and out-of-state IDs
        tm = 8'h17;
        irq[1] = 1'b1; cyc(); irq[1] = 1'b0; cyc();
        snap_ip = ip_o; snap_busy = busy_o;
        chk("inv_setup", snap_ip, 8'h02);
        claim(0); claim(9); complete(2);
        chk("inv_ip_same", ip_o, snap_ip);
        chk("inv_busy_same", busy_o, snap_busy);
        claim_vld = 1'b1; claim_id = 4'd2; comp_vld = 1'b1; comp_id = 4'd5;
        cyc();
        claim_vld = 1'b0; comp_vld = 1'b0;
        chk("conc_busy", busy_o, 8'h02);
        chk("conc_ip", ip_o, 8'h00);

        // Reset mid-operation with cnt = 2 on a claimed and a pending source
        for (int k = 0; k < 2; k++) begin
            irq = 8'h16; cyc();
            irq = 8'h10; cyc();
        end
        chk("mid_ip", ip_o, 8'h04);
        chk("mid_busy", busy_o, 8'h02);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        chk("mid_rst_ip", ip_o, 8'h00);
        chk("mid_rst_busy", busy_o, 8'h00);
        cyc(); cyc(); cyc();
        chk("mid_no_repend", ip_o | busy_o, 8'h00);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            if (c % 16 == 0) begin
                tm  = 8'($urandom);
                pol = 8'($urandom);
                tnm = 4'($urandom_range(0, 5));
            end
            irq       = 8'($urandom);
            claim_vld = ($urandom_range(0, 2) != 0);
            claim_id  = 4'($urandom_range(0, 10));
            comp_vld  = ($urandom_range(0, 2) != 0);
            comp_id   = 4'($urandom_range(0, 10));
            rst_n     = ($urandom_range(0, 63) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/plic_gateway_array.md
# plic_gateway_array

Parametrised multi-source interrupt gateway for the PLIC. It replaces per-source single-instance gateways with one array of `SRC_NUM` channels. Each channel has:
- per-source trigger mode and polarity;
- a saturating edge-request counter with runtime limit, plus an overflow flag;
- an ID-addressed claim/complete interface.

It sits between the raw (already synchronised) interrupt lines and the PLIC priority/target core. Its `ip_o` vector feeds the pending bits.

## Interface
Parameters:
- `SRC_NUM`, default 8: number of interrupt sources, 1..1023. Source bit i has interrupt ID i+1; ID 0 means "no interrupt".
- `CNT_WIDTH`, default 4: width of each edge-request counter.
- `ID_WIDTH`, default $clog2(SRC_NUM+1): width of the claim/complete ID fields.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_n_i`  in  1  reset. One clock; reset is synchronous and active-low.
- `irq_i`  in  SRC_NUM  raw interrupt lines, synchronous to `clk_i`.
- `tm_i`  in  SRC_NUM  trigger mode per source: 0 = level, 1 = edge.
- `pol_i`  in  SRC_NUM  polarity per source: 0 = active-high level / rising edge; 1 = active-low level / falling edge.
- `tnm_i`  in  CNT_WIDTH  global edge-count limit; 0 is treated as 1.
- `claim_vld_i`  in  1  claim strobe, single cycle.
- `claim_id_i`  in  ID_WIDTH  ID being claimed.
- `comp_vld_i`  in  1  completion strobe, single cycle.
- `comp_id_i`  in  ID_WIDTH  ID being completed.
- `ip_o`  out  SRC_NUM  pending to PLIC core, registered.
- `busy_o`  out  SRC_NUM  source is claimed and awaiting completion, registered.
- `ovf_o`  out  SRC_NUM  one-cycle pulse: an edge was dropped because the counter was saturated.

## Operation
Per channel i:
- **Input normalisation and edge detect**
  - `act = irq_i[i] ^ pol_i[i]`.
  - `act_q` is the registered copy of `act`; reset value 0.
  - `edge = act & ~act_q`.
- **Counter `cnt`** (CNT_WIDTH bits, reset 0), with `lim = (tnm_i == 0) ? 1 : tnm_i`:
  - `tm_i[i]` = 0 (level): `cnt` is forced to 0 every cycle.
  - `tm_i[i]` = 1 (edge):
    - `edge` without consume: `cnt + 1` if `cnt < lim`; otherwise `cnt` is held and `ovf_o[i]` pulses.
    - consume without `edge`: `cnt - 1`, floor 0.
    - `edge` and consume together: `cnt` is unchanged and there is no overflow.
  - "Consume" means a valid claim of ID i+1 while the channel is in PEND.
  - If `lim` is lowered below the current `cnt`, `cnt` is not truncated; it drains by consumes only.
- **FSM** (states IDLE, PEND, CLAIMED; reset IDLE):
  - IDLE → PEND when (level mode and `act`) or (edge mode and next-cycle `cnt` != 0).
  - PEND → CLAIMED on `claim_vld_i` with `claim_id_i` == i+1.
  - CLAIMED → IDLE on `comp_vld_i` with `comp_id_i` == i+1.
  - Claims in IDLE or CLAIMED, and completions in IDLE or PEND, are ignored with no state change.
  - Claim/complete IDs of 0 or > SRC_NUM are ignored by all channels.
  - A claim and a completion in the same cycle are evaluated independently per channel. Different IDs both take effect. The same ID acts only on whichever state the channel is currently in.
  - A level source going inactive while in PEND stays pending until claimed; the gateway does not retract.
- **Outputs**:
  - `ip_o[i]` = (state == PEND).
  - `busy_o[i]` = (state == CLAIMED).
  - Both are decoded from the state register, so no combinational path exists from inputs to outputs.
- **Mode changes**: changing `tm_i`/`pol_i` at runtime does not reset the FSM. Level mode clears `cnt` on the next edge. A polarity flip may produce one spurious `edge`; software masks the source around reconfiguration.

## Timing
- **Reset**: `rst_n_i` low at a rising edge sets all states to IDLE and all `cnt`, `act_q`, `ip_o`, `busy_o`, `ovf_o` to 0. This applies mid-operation too; pending and claimed requests are discarded.
- **Assertion latency**: `act` first sampled true at edge k → `ip_o[i]` high after edge k, for both modes.
- **Claim**: claim sampled at edge m → `ip_o[i]` low and `busy_o[i]` high after edge m; `cnt` decremented at edge m.
- **Complete**: completion sampled at edge n → `busy_o[i]` low after edge n.
- **Re-pend**: `ip_o[i]` reasserts after edge n+1 if `cnt` != 0 or the level source is still active, giving a minimum one-cycle IDLE gap.
- **Overflow**: `ovf_o[i]` is high for exactly the cycle following the edge at which the request was dropped.
- **Throughput**: back-to-back edges (act toggling every cycle) register one request per rising transition.

## Test plan
- **Reset and level mode**: reset, then `tm`=0, `pol`=0, `irq[0]`=1 at edge 3 → `ip_o`=0x01 after edge 3. Claim ID 1 at edge 5 → `ip_o`=0, `busy_o`=0x01. Complete at edge 7 with irq still high → `ip_o`=0x01 after edge 8.
- **Edge counting and saturation**: `tm`=1, `tnm`=3, 5 rising edges on source 2 before any claim → `cnt`=3, `ovf_o[2]` pulses twice. Three claim/complete cycles each re-pend; after the third completion `ip_o[2]` stays 0.
- **Simultaneous edge and claim**: `cnt`=1 on source 0, rising edge on the same edge as claim ID 1 → `cnt` stays 1, no `ovf`. After completion, `ip_o[0]` reasserts.
- **Falling-edge polarity**: `pol[4]`=1, irq held high then dropped → `ip_o[4]` high after the sampling edge of the low value. The rising transition produces nothing.
- **Invalid and out-of-state IDs**:
  - claim ID 0, claim ID `SRC_NUM`+1, and complete of a PEND source → no state change anywhere;
  - concurrent claim ID 2 and complete ID 5 (5 in CLAIMED) → both take effect.
- **Reset mid-operation**: sources in PEND and CLAIMED with `cnt`=2, then `rst_n_i` low for one edge → all outputs 0, and no re-pend without new edges.
